// File: rtl/sauria_uart_dbg_responder.sv
// UART debug preload responder: parses byte-stream command frames (write/read/run)
// into single 32-bit accesses on an OBI-style port and returns ACK/NAK plus read data.
module sauria_uart_dbg_responder #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_err_i,
  output logic                 launch_o,
  output logic [AddrWidth-1:0] launch_addr_o,
  output logic                 busy_o
);

  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TimeoutCycles - 1);
  localparam logic [7:0] Ack = 8'hA5;
  localparam logic [7:0] Nak = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_MEM_REQ, S_MEM_WAIT, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_WR, OP_RD, OP_RUN
  } op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            last_q, last_d;
  logic                  nak_q, nak_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  launch_q, launch_d;
  logic [AddrWidth-1:0]  launch_addr_q, launch_addr_d;

  logic        rx_fire;
  logic [31:0] full_addr;
  logic        aligned;
  logic [7:0]  tx_byte;

  assign rx_ready_o = !rst_i && (state_q inside {S_IDLE, S_ADDR, S_DATA});
  assign rx_fire    = rx_valid_i && rx_ready_o;
  // Completed address as seen while the final address byte is on the bus.
  assign full_addr  = {rx_data_i, addr_q[23:0]};
  assign aligned    = (addr_q[1:0] == 2'b00);

  always_comb begin
    tx_byte = 8'h00;
    case (cnt_q)
      3'd0:    tx_byte = nak_q ? Nak : Ack;
      3'd1:    tx_byte = rdata_q[7:0];
      3'd2:    tx_byte = rdata_q[15:8];
      3'd3:    tx_byte = rdata_q[23:16];
      3'd4:    tx_byte = rdata_q[31:24];
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    nak_d         = nak_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    timer_d       = timer_q;
    launch_d      = 1'b0;
    launch_addr_d = launch_addr_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_fire) begin
          cnt_d  = 3'd0;
          last_d = 3'd0;
          nak_d  = 1'b0;
          case (rx_data_i)
            8'h01: begin op_d = OP_WR;  state_d = S_ADDR; end
            8'h02: begin op_d = OP_RD;  state_d = S_ADDR; end
            8'h03: begin op_d = OP_RUN; state_d = S_ADDR; end
            default: begin nak_d = 1'b1; state_d = S_RESP; end
          endcase
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          timer_d = '0;
          addr_d[cnt_q[1:0]*8 +: 8] = rx_data_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            case (op_q)
              OP_WR: state_d = S_DATA;
              OP_RD: begin
                nak_d   = !aligned;
                state_d = aligned ? S_MEM_REQ : S_RESP;
              end
              default: begin
                nak_d   = !aligned;
                state_d = S_RESP;
                if (aligned) begin
                  launch_d      = 1'b1;
                  launch_addr_d = full_addr[AddrWidth-1:0];
                end
              end
            endcase
          end
        end else if (timer_q == TimerLast) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DATA: begin
        if (rx_fire) begin
          timer_d = '0;
          wdata_d[cnt_q[1:0]*8 +: 8] = rx_data_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            // Data bytes are always consumed so the host stays framed, even on NAK.
            cnt_d   = 3'd0;
            nak_d   = !aligned;
            state_d = aligned ? S_MEM_REQ : S_RESP;
          end
        end else if (timer_q == TimerLast) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_MEM_REQ: begin
        if (mem_gnt_i) state_d = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        if (mem_rvalid_i) begin
          cnt_d   = 3'd0;
          nak_d   = mem_err_i;
          state_d = S_RESP;
          if (!mem_err_i) begin
            rdata_d = mem_rdata_i;
            if (op_q == OP_RD) last_d = 3'd4;
          end
        end
      end

      S_RESP: begin
        if (tx_ready_i) begin
          if (cnt_q == last_q) begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      op_q          <= OP_WR;
      cnt_q         <= 3'd0;
      last_q        <= 3'd0;
      nak_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      timer_q       <= '0;
      launch_q      <= 1'b0;
      launch_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      nak_q         <= nak_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      timer_q       <= timer_d;
      launch_q      <= launch_d;
      launch_addr_q <= launch_addr_d;
    end
  end

  assign tx_valid_o    = !rst_i && (state_q == S_RESP);
  assign tx_data_o     = tx_valid_o ? tx_byte : 8'h00;
  assign mem_req_o     = !rst_i && (state_q == S_MEM_REQ);
  assign mem_we_o      = mem_req_o && (op_q == OP_WR);
  assign mem_addr_o    = addr_q[AddrWidth-1:0];
  assign mem_wdata_o   = wdata_q;
  assign mem_be_o      = 4'hF;
  assign launch_o      = !rst_i && launch_q;
  assign launch_addr_o = launch_addr_q;
  assign busy_o        = !rst_i && (state_q != S_IDLE);

endmodule

// File: tb/tb_sauria_uart_dbg_responder.sv
// Bench for the UART debug responder: table of frames with a TX byte scoreboard,
// a small memory responder, and hand sequences for timeout/backpressure/reset.
module tb_sauria_uart_dbg_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic        launch_o;
  logic [31:0] launch_addr_o;
  logic        busy_o;

  sauria_uart_dbg_responder #(.AddrWidth(32), .TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .launch_o(launch_o), .launch_addr_o(launch_addr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- TX scoreboard ----------------
  logic [7:0] tx_q[$];
  int launch_cnt = 0;
  logic launch_prev = 1'b0;

  always @(negedge clk_i) begin
    if (tx_valid_o && tx_ready_i) begin
      if (tx_q.size() == 0) chk("tx_unexpected_byte", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, tx_data_o}, {24'd0, tx_q.pop_front()});
    end
    if (launch_o) begin
      launch_cnt++;
      if (launch_prev) chk("launch_single_cycle", 32'd1, 32'd0);
    end
    launch_prev = launch_o;
  end

  // ---------------- memory responder ----------------
  int          gnt_delay = 0;
  int          rvalid_delay = 0;
  logic [31:0] cur_rdata = '0;
  logic        cur_err = 1'b0;
  int          req_cnt = 0;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [3:0]  req_be;

  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_req_o) begin
        req_cnt++;
        req_addr = mem_addr_o; req_wdata = mem_wdata_o; req_we = mem_we_o; req_be = mem_be_o;
        for (int i = 0; i < gnt_delay; i++) begin
          @(negedge clk_i);
          chk("hold_req", {31'd0, mem_req_o}, 32'd1);
          chk("hold_addr", mem_addr_o, req_addr);
          chk("hold_wdata", mem_wdata_o, req_wdata);
          chk("hold_we_be", {27'd0, mem_we_o, mem_be_o}, {27'd0, req_we, req_be});
          @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        for (int i = 0; i < rvalid_delay; i++) begin @(posedge clk_i); #1; end
        mem_rvalid_i = 1'b1; mem_rdata_i = cur_rdata; mem_err_i = cur_err;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk_i); #1;
    rx_data_i = b; rx_valid_i = 1'b1; n = 0;
    forever begin
      @(negedge clk_i);
      if (rx_ready_o) break;
      n++;
      if (n > 200) begin chk("rx_accept_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    forever begin
      @(negedge clk_i);
      if (tx_q.size() == 0 && !busy_o) break;
      n++;
      if (n > 500) begin chk({nm, "_idle_timeout"}, 32'd0, 32'd1); tx_q.delete(); break; end
    end
  endtask

  typedef struct {
    logic [8:0][7:0] frame;
    int              nb;
    logic [31:0]     rdata;
    logic            err;
    logic [4:0][7:0] tx;
    int              ntx;
    int              nreq;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    int              nlaunch;
  } vec_t;

  function automatic vec_t mkv(logic [71:0] fr, int nb, logic [31:0] rd, logic er,
                               logic [39:0] tx, int ntx, int nreq, logic we,
                               logic [31:0] a, logic [31:0] wd, int nl);
    vec_t v;
    v.frame = fr; v.nb = nb; v.rdata = rd; v.err = er; v.tx = tx; v.ntx = ntx;
    v.nreq = nreq; v.we = we; v.addr = a; v.wdata = wd; v.nlaunch = nl;
    return v;
  endfunction

  vec_t tab[7];

  initial begin
    int r0, l0, n;
    logic [7:0] f[$];

    // frames are written byte0-in-LSB; tx likewise (first byte in LSB)
    tab[0] = mkv(72'hDEADBEEF1000000001, 9, 32'h0, 1'b0, 40'hA5, 1, 1, 1'b1, 32'h10000000, 32'hDEADBEEF, 0);
    tab[1] = mkv(72'h1000000402, 5, 32'h12345678, 1'b0, 40'h12345678A5, 5, 1, 1'b0, 32'h10000004, 32'h0, 0);
    tab[2] = mkv(72'h7F, 1, 32'h0, 1'b0, 40'hEE, 1, 0, 1'b0, 32'h0, 32'h0, 0);
    tab[3] = mkv(72'h1000000202, 5, 32'h0, 1'b0, 40'hEE, 1, 0, 1'b0, 32'h0, 32'h0, 0);
    tab[4] = mkv(72'h1000000802, 5, 32'hFFFFFFFF, 1'b1, 40'hEE, 1, 1, 1'b0, 32'h10000008, 32'h0, 0);
    tab[5] = mkv(72'h8000000003, 5, 32'h0, 1'b0, 40'hA5, 1, 0, 1'b0, 32'h0, 32'h0, 1);
    tab[6] = mkv(72'h2000010002, 5, 32'hA0B1C2D3, 1'b0, 40'hA0B1C2D3A5, 5, 1, 1'b0, 32'h20000100, 32'h0, 0);

    rst_i = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("rst_tx", {23'd0, tx_valid_o, tx_data_o}, 32'd0);
    chk("rst_mem_ctl", {26'd0, mem_req_o, mem_we_o, mem_be_o}, 32'h0000000F);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_launch_busy", {30'd0, launch_o, busy_o}, 32'd0);
    chk("rst_launch_addr", launch_addr_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1 chk("rx_ready_after_rst", {31'd0, rx_ready_o}, 32'd1);

    // ---- table-driven frames ----
    foreach (tab[i]) begin
      cur_rdata = tab[i].rdata; cur_err = tab[i].err;
      r0 = req_cnt; l0 = launch_cnt;
      for (int j = 0; j < tab[i].ntx; j++) tx_q.push_back(tab[i].tx[j]);
      for (int j = 0; j < tab[i].nb; j++) send_byte(tab[i].frame[j]);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_nreq", i), req_cnt - r0, tab[i].nreq);
      if (tab[i].nreq > 0) begin
        chk($sformatf("vec%0d_addr", i), req_addr, tab[i].addr);
        chk($sformatf("vec%0d_we_be", i), {27'd0, req_we, req_be}, {27'd0, tab[i].we, 4'hF});
        if (tab[i].we) chk($sformatf("vec%0d_wdata", i), req_wdata, tab[i].wdata);
      end
      chk($sformatf("vec%0d_nlaunch", i), launch_cnt - l0, tab[i].nlaunch);
      if (tab[i].nlaunch > 0) chk($sformatf("vec%0d_launch_addr", i), launch_addr_o, 32'h80000000);
    end

    // ---- READ with TX stalled mid-stream ----
    cur_rdata = 32'h12345678; cur_err = 1'b0;
    f = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h10};
    tx_q = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (f[j]) send_byte(f[j]);
    n = 0;
    forever begin
      @(posedge clk_i); #1;
      if (tx_valid_o && tx_data_o == 8'h56) break;
      n++;
      if (n > 50) begin chk("bp_find_byte", 32'd0, 32'd1); break; end
    end
    tx_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_hold", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, 8'h56});
    end
    @(posedge clk_i); #1;
    tx_ready_i = 1'b1;
    wait_idle("bp");

    // ---- inter-byte timeout, then a normal READ with latency check ----
    r0 = req_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (20) @(negedge clk_i);
    chk("timeout_idle", {31'd0, busy_o}, 32'd0);
    chk("timeout_noreq", req_cnt - r0, 32'd0);
    cur_rdata = 32'hCAFEF00D;
    f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_q = '{8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    foreach (f[j]) send_byte(f[j]);
    @(negedge clk_i); chk("lat_c1", {31'd0, tx_valid_o}, 32'd0);
    @(negedge clk_i); chk("lat_c2", {31'd0, tx_valid_o}, 32'd0);
    @(negedge clk_i); chk("lat_c3", {31'd0, tx_valid_o}, 32'd1);
    wait_idle("after_timeout");
    chk("after_timeout_addr", req_addr, 32'h00000000);

    // ---- grant held off 10 cycles ----
    gnt_delay = 10;
    f = '{8'h01, 8'h0C, 8'h00, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
    tx_q = '{8'hA5};
    foreach (f[j]) send_byte(f[j]);
    wait_idle("gnt_hold");
    chk("gnt_hold_addr", req_addr, 32'h2000000C);
    chk("gnt_hold_wdata", req_wdata, 32'h44332211);
    gnt_delay = 0;

    // ---- reset while waiting for rvalid ----
    rvalid_delay = 3;
    cur_rdata = 32'h55AA55AA;
    f = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h10};
    foreach (f[j]) send_byte(f[j]);
    @(posedge clk_i); #1;
    chk("rstw_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rstw_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("rstw_tx", {23'd0, tx_valid_o, tx_data_o}, 32'd0);
    chk("rstw_mem_ctl", {26'd0, mem_req_o, mem_we_o, mem_be_o}, 32'h0000000F);
    chk("rstw_mem_addr", mem_addr_o, 32'd0);
    chk("rstw_mem_wdata", mem_wdata_o, 32'd0);
    chk("rstw_launch_busy", {30'd0, launch_o, busy_o}, 32'd0);
    chk("rstw_launch_addr", launch_addr_o, 32'd0);
    rst_i = 1'b0;
    #1 chk("rstw_rx_ready_after", {31'd0, rx_ready_o}, 32'd1);
    repeat (12) @(negedge clk_i);
    chk("rstw_idle", {31'd0, busy_o}, 32'd0);
    rvalid_delay = 0;

    repeat (3) @(negedge clk_i);
    chk("tx_queue_drained", tx_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sauria_uart_dbg_responder.md
Name: sauria_uart_dbg_responder

Overview:
- Device-side responder for the UART debug preload protocol driven by the testbench VIP (ELF load, run, exit-code polling).
- Consumes deserialized RX bytes, parses command frames, and issues 32-bit accesses on an OBI-style memory port.
- Returns ACK/NAK and read data as TX bytes; can launch execution at a given address.
- Sits between the UART byte engine and the SoC crossbar, in the SAURIA demonstrator.

Parameters:
- AddrWidth, 32, width of mem_addr_o/launch_addr_o; frame address bits above AddrWidth are ignored.
- TimeoutCycles, 100000, maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  received byte valid
- rx_ready_o  out  1  byte accepted when high with rx_valid_i
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  response byte valid
- tx_ready_i  in  1  UART TX accepts byte
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  AddrWidth  word-aligned address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables (always 4'hF)
- mem_gnt_i  in  1  request granted
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i
- launch_o  out  1  one-cycle run pulse
- launch_addr_o  out  AddrWidth  entry address, held until next launch
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Frame format: opcode byte, then 4 address bytes, little-endian.
  - 0x01 WRITE: address, then 4 data bytes LE; response 0xA5.
  - 0x02 READ: address; response 0xA5 followed by 4 data bytes LE.
  - 0x03 RUN: address; launch_o pulses, response 0xA5.
  - Any other opcode: response 0xEE (NAK), no further bytes consumed for that frame.
- States: IDLE, ADDR, DATA, MEM_REQ, MEM_WAIT, RESP.
  - IDLE: accept opcode. Valid opcode → ADDR; invalid → RESP with NAK.
  - ADDR: 4 bytes. Then WRITE → DATA; READ → MEM_REQ; RUN → RESP.
  - DATA: 4 bytes, then → MEM_REQ.
  - MEM_REQ: hold mem_req_o and all request fields stable until mem_gnt_i; then → MEM_WAIT.
  - MEM_WAIT: wait for mem_rvalid_i; capture mem_rdata_i; → RESP.
  - RESP: emit the queued bytes; → IDLE after the last handshake.
- RUN side effects: launch_addr_o is updated and launch_o pulses in the cycle the RUN frame enters RESP. Both happen only if the address is aligned.
- Address alignment: addr[1:0] != 0 on READ/WRITE/RUN → NAK, no memory access, no launch.
- Bus error: mem_err_i with mem_rvalid_i → NAK only; no data bytes are sent for a READ.
- rx_ready_o: high only in IDLE, ADDR, DATA. Each byte is consumed on rx_valid_i && rx_ready_o.
- TX handshake:
  - tx_valid_o stays high and tx_data_o stable until tx_ready_i.
  - A byte counter sequences multi-byte responses.
  - No bubbles are required between bytes.
- Inter-byte timeout:
  - Counter resets on every accepted byte and while in IDLE.
  - Counts only in ADDR/DATA.
  - Reaching TimeoutCycles → IDLE, partial frame discarded, no response.
- Memory phases have no timeout.
- Bytes arriving during MEM_*/RESP are back-pressured, never dropped.
- Reset: synchronous, takes priority over everything, aborts any frame.
  - Reset values: state IDLE; rx_ready_o 0; tx_valid_o 0, tx_data_o 0; mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0; mem_be_o 4'hF; launch_o 0, launch_addr_o 0; busy_o 0.
  - rx_ready_o goes high the first cycle after reset deasserts.
  - Reset during MEM_WAIT: the later rvalid is ignored.
- Latency: with gnt in the same cycle and rvalid one cycle later, the first response byte is valid 3 cycles after the last frame byte.

Test Plan:
- WRITE: send 01 00 00 00 10 EF BE AD DE → one write of 0xDEADBEEF to 0x10000000, mem_be_o=F; TX emits A5.
- READ: send 02 04 00 00 10, mem_rdata_i=0x12345678 → TX emits A5 78 56 34 12. Hold tx_ready_i low 5 cycles mid-stream → no byte lost or reordered.
- RUN: send 03 00 00 00 80 → launch_o high exactly 1 cycle, launch_addr_o=0x80000000; TX emits A5.
- Invalid and error cases:
  - Opcode 0x7F → TX EE, no memory request.
  - READ at 0x10000002 → EE, no request.
  - READ with mem_err_i → EE only.
- Timeout: TimeoutCycles=16, send 01 00 then stall 16 cycles → back in IDLE with no TX. Next frame 02 00 00 00 00 is processed normally.
- Reset and backpressure:
  - rst_i asserted in MEM_WAIT → all outputs at reset values; a late rvalid produces no TX.
  - Hold mem_gnt_i low 10 cycles → request fields stable throughout.
